// File: rtl/uart_receiver.sv
// 8N1 UART receive stage: synchronises rx, recovers frames and buffers bytes on a valid/ready stream.
// Define UART_RX_FIFO_EN for a FIFO_DEPTH-entry circular buffer; otherwise a single holding register.
module uart_receiver #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] dout,
  output logic       dout_valid,
  input  logic       dout_ready,
  output logic       framing_err,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] HalfCnt = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 4) begin : g_bad_clks
    $error("CLKS_PER_BIT must be at least 4");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two and at least 2");
  end

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  logic            rx_meta_q, rx_s;
  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            push, frame_bad;
  logic            full, pop, accept;
  logic            framing_err_q, overrun_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s      <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s      <= rx_meta_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    push      = 1'b0;
    frame_bad = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!rx_s) begin
          state_d = StStart;
          cnt_d   = '0;
        end
      end
      StStart: begin
        // A start bit that is high again at its midpoint is treated as a glitch.
        if (cnt_q == HalfCnt) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s ? StIdle : StData;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StData: begin
        if (cnt_q == FullCnt) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = StStop;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StStop: begin
        // Return to idle at the stop-bit midpoint so a following start bit is not missed.
        if (cnt_q == FullCnt) begin
          cnt_d     = '0;
          state_d   = StIdle;
          push      = rx_s;
          frame_bad = !rx_s;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy   = (state_q != StIdle);
  assign pop    = dout_valid && dout_ready;
  assign accept = push && (!full || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      framing_err_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      framing_err_q <= frame_bad;
      overrun_q     <= push && full && !pop;
    end
  end

  assign framing_err = framing_err_q;
  assign overrun     = overrun_q;

`ifdef UART_RX_FIFO_EN
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   count_q;

  assign full = (count_q == (PtrW + 1)'(FIFO_DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (accept) begin
        mem_q[wr_ptr_q] <= shift_q;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({accept, pop})
        2'b10:   count_q <= count_q + (PtrW + 1)'(1);
        2'b01:   count_q <= count_q - (PtrW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign dout       = mem_q[rd_ptr_q];
  assign dout_valid = (count_q != '0);
`else
  logic [7:0] hold_q;
  logic       valid_q;

  assign full = valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q  <= '0;
      valid_q <= 1'b0;
    end else if (accept) begin
      hold_q  <= shift_q;
      valid_q <= 1'b1;
    end else if (pop) begin
      valid_q <= 1'b0;
    end
  end

  assign dout       = hold_q;
  assign dout_valid = valid_q;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Randomised scoreboard bench for uart_receiver; a queue model of the receive buffer predicts
// every delivered byte and the number of framing/overrun pulses.
module tb_uart_receiver;

  localparam int CPB = 16;
  localparam int FD  = 4;
`ifdef UART_RX_FIFO_EN
  localparam int EffDepth = FD;
`else
  localparam int EffDepth = 1;
`endif
  // Nominal start-edge to dout_valid latency; the DUT may be one cycle either side.
  localparam int LatNom = 2 + 1 + CPB / 2 + 9 * CPB + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       dout_ready = 1'b0;
  logic [7:0] dout;
  logic       dout_valid, framing_err, overrun, busy;

  uart_receiver #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (FD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .framing_err(framing_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks = 0, passes = 0, cyc = 0;
  logic [7:0] exp_q[$];
  int exp_ferr = 0, exp_ovr = 0, occ = 0;
  int seen_ferr = 0, seen_ovr = 0, seen_busy = 0, n_bytes = 0;
  int rise_cyc = -1, start_cyc = 0;
  logic prev_valid = 1'b0, prev_ready = 1'b0;
  logic [7:0] prev_dout = 8'h00;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: samples on the falling edge, when inputs and outputs are settled.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      prev_valid = 1'b0;
      prev_ready = 1'b0;
    end else begin
      if (prev_valid && !prev_ready) begin
        check("stall_valid_held", int'(dout_valid), 1);
        check("stall_dout_held", int'(dout), int'(prev_dout));
      end
      if (dout_valid && dout_ready) begin
        n_bytes++;
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_byte: got 0x%0h, required no byte", dout);
        end else begin
          check("dout_byte", int'(dout), int'(exp_q.pop_front()));
        end
      end
      if (framing_err) seen_ferr++;
      if (overrun) seen_ovr++;
      if (busy) seen_busy++;
      if (dout_valid && !prev_valid) rise_cyc = cyc;
      prev_valid = dout_valid;
      prev_ready = dout_ready;
      prev_dout  = dout;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passes, checks);
    $fatal(1, "watchdog expired");
  end

  // Reference model: drain_mode = consumer takes bytes as they arrive; pop_same = consumer pops
  // on the very cycle this frame's byte would be written.
  task automatic ref_frame(input logic [7:0] b, input bit stop_ok, input bit drain_mode,
                           input bit pop_same);
    if (!stop_ok) exp_ferr++;
    else if (drain_mode) exp_q.push_back(b);
    else if (occ < EffDepth) begin
      exp_q.push_back(b);
      occ++;
    end else if (pop_same) exp_q.push_back(b);
    else exp_ovr++;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic v);
    rx = v;
    cycles(CPB);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit drain_mode,
                            input bit pop_same);
    ref_frame(b, stop_ok, drain_mode, pop_same);
    start_cyc = cyc;
    drive(1'b0);
    for (int i = 0; i < 8; i++) drive(b[i]);
    drive(stop_ok);
    if (!stop_ok) drive(1'b1);
  endtask

  task automatic drain(input string name);
    dout_ready = 1'b1;
    for (int i = 0; i < 200 && dout_valid; i++) cycles(1);
    cycles(2);
    check({name, "_empty"}, int'(dout_valid), 0);
    check({name, "_all_delivered"}, exp_q.size(), 0);
    occ = 0;
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_dout"}, int'(dout), 0);
    check({name, "_dout_valid"}, int'(dout_valid), 0);
    check({name, "_framing_err"}, int'(framing_err), 0);
    check({name, "_overrun"}, int'(overrun), 0);
    check({name, "_busy"}, int'(busy), 0);
  endtask

  initial begin
    int b0, lat;
    logic [7:0] rb;
    logic [7:0] part;

    cycles(3);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    cycles(2);

    // Single byte with a ready consumer.
    dout_ready = 1'b1;
    send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
    cycles(4);
    lat = rise_cyc - start_cyc;
    check("a5_latency_in_window", int'(lat >= LatNom - 1 && lat <= LatNom + 1), 1);
    check("a5_byte_count", n_bytes, 1);
    check("a5_no_errors", seen_ferr + seen_ovr, 0);

    // Short low pulse: start bit rejected.
    b0 = n_bytes;
    seen_busy = 0;
    rx = 1'b0;
    cycles(4);
    rx = 1'b1;
    cycles(2 * CPB);
    check("glitch_busy_seen", int'(seen_busy > 0), 1);
    check("glitch_back_idle", int'(busy), 0);
    check("glitch_no_byte", n_bytes, b0);
    check("glitch_no_framing_err", seen_ferr, 0);

    // Low stop bit, then a good frame.
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
    send_frame(8'h81, 1'b1, 1'b1, 1'b0);
    cycles(4);
    check("framing_err_cycles", seen_ferr, exp_ferr);
    check("framing_next_byte", n_bytes, b0 + 1);

    // Overrun: stalled consumer, one frame more than the buffer holds.
    dout_ready = 1'b0;
    occ = 0;
    for (int i = 1; i <= EffDepth + 1; i++) send_frame(8'(i), 1'b1, 1'b0, 1'b0);
    cycles(4);
    check("overrun_cycles", seen_ovr, exp_ovr);
    drain("overrun_drain");

    // Back-to-back frames; consumer pops exactly as the last byte lands in a full buffer.
    dout_ready = 1'b0;
    for (int i = 0; i < EffDepth - 1; i++) begin
      rb = 8'($urandom);
      send_frame(rb, 1'b1, 1'b0, 1'b0);
    end
    send_frame(8'h55, 1'b1, 1'b0, 1'b0);
    fork
      send_frame(8'hAA, 1'b1, 1'b0, 1'b1);
      begin
        cycles(LatNom - 2);
        dout_ready = 1'b1;
      end
    join
    cycles(4);
    check("b2b_no_overrun", seen_ovr, exp_ovr);
    drain("b2b_drain");

    // Random bytes, occasional bad stop bits, random idle gaps.
    dout_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      rb = 8'($urandom);
      send_frame(rb, $urandom_range(0, 5) != 0, 1'b1, 1'b0);
      cycles($urandom_range(0, 20));
    end
    cycles(4);
    check("random_framing_errs", seen_ferr, exp_ferr);
    check("random_overruns", seen_ovr, exp_ovr);
    drain("random_drain");

    // Reset in the middle of data bit 3.
    part = 8'hC3;
    drive(1'b0);
    for (int i = 0; i < 3; i++) drive(part[i]);
    rx = part[3];
    cycles(CPB / 2);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midframe_reset");
    rx = 1'b1;
    cycles(3);
    rst_n = 1'b1;
    cycles(4);
    b0 = n_bytes;
    send_frame(8'h5A, 1'b1, 1'b1, 1'b0);
    cycles(4);
    check("after_reset_byte_count", n_bytes, b0 + 1);
    drain("final");
    check("total_framing_errs", seen_ferr, exp_ferr);
    check("total_overruns", seen_ovr, exp_ovr);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
